// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-pipelined adder/subtractor.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  localparam int MAX_WIDTH = 32;

  // One pipeline stage's worth of state. Vectors are sized for the widest
  // legal adder and masked down to the configured WIDTH by each stage.
  // carry_prev keeps the carry that entered the stage, so that the final
  // stage can form the signed overflow as c(WIDTH) xor c(WIDTH-1).
  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic                 carry_prev;
    logic [MAX_WIDTH-1:0] a_rem;
    logic [MAX_WIDTH-1:0] b_rem;
  } stage_t;

  // Ones in bit positions 0..w-1, zeros above.
  function automatic logic [MAX_WIDTH-1:0] width_mask(input int w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Handshake and data bundle between the operand source, the adder and the
// result consumer.
interface pipelined_adder_nbit_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             ovf_sticky;
  logic             ovf_clr;

  modport master (
    output in_valid, a, b, cin, sub, out_ready, ovf_clr,
    input  in_ready, out_valid, sum, cout, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready, ovf_clr,
    output in_ready, out_valid, sum, cout, ovf, ovf_sticky
  );

endinterface

// File: rtl/adder_stage.sv
// One bit of the ripple-carry chain: a full adder on bit STAGE_IDX plus
// registers carrying the partial sum, the carry and the unused operand bits
// on to the next stage.
module adder_stage
  import adder_pkg::*;
#(
  parameter int STAGE_IDX = 0,
  parameter int WIDTH     = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  localparam logic [MAX_WIDTH-1:0] KEEP_MASK = width_mask(WIDTH);

  logic   a_bit;
  logic   b_bit;
  logic   s_bit;
  logic   c_out;
  stage_t nxt;

  // Full-adder on this stage's bit; the consumed operand bits are zeroed so
  // only the not-yet-used bits travel on.
  always_comb begin
    a_bit = d.a_rem[STAGE_IDX];
    b_bit = d.b_rem[STAGE_IDX];
    s_bit = a_bit ^ b_bit ^ d.carry;
    c_out = (a_bit & b_bit) | (d.carry & (a_bit ^ b_bit));

    nxt                  = d;
    nxt.sum[STAGE_IDX]   = s_bit;
    nxt.carry_prev       = d.carry;
    nxt.carry            = c_out;
    nxt.a_rem[STAGE_IDX] = 1'b0;
    nxt.b_rem[STAGE_IDX] = 1'b0;
    nxt.sum              = nxt.sum   & KEEP_MASK;
    nxt.a_rem            = nxt.a_rem & KEEP_MASK;
    nxt.b_rem            = nxt.b_rem & KEEP_MASK;
  end

  // Stage register; holds while the pipe is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit adder/subtractor pipelined one bit per stage, with valid/ready
// flow control, a global stall and a sticky signed-overflow flag.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_adder_nbit_if.slave  bus
);

  stage_t entry;
  stage_t chain [WIDTH];
  logic   stall;
  logic   en;
  logic   ovf_sticky_q;

  // The whole pipe freezes only when a valid result is waiting on the
  // consumer; bubbles at the output never block the pipe.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = ~stall;

  // Subtraction is a + ~b + 1, so the mode is folded into the operands and
  // the carry-in before the first stage sees them.
  always_comb begin
    entry                  = '0;
    entry.valid            = bus.in_valid;
    entry.carry            = (bus.sub == SUB) ? 1'b1 : bus.cin;
    entry.a_rem[WIDTH-1:0] = bus.a;
    entry.b_rem[WIDTH-1:0] = (bus.sub == SUB) ? ~bus.b : bus.b;
  end

  for (genvar s = 0; s < WIDTH; s++) begin : g_stage
    if (s == 0) begin : g_first
      adder_stage #(.STAGE_IDX(s), .WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (entry),
        .q   (chain[s])
      );
    end else begin : g_rest
      adder_stage #(.STAGE_IDX(s), .WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (chain[s-1]),
        .q   (chain[s])
      );
    end
  end

  assign bus.out_valid  = chain[WIDTH-1].valid;
  assign bus.sum        = chain[WIDTH-1].sum[WIDTH-1:0];
  assign bus.cout       = chain[WIDTH-1].carry;
  assign bus.ovf        = chain[WIDTH-1].carry ^ chain[WIDTH-1].carry_prev;
  assign bus.ovf_sticky = ovf_sticky_q;

  // Sticky overflow: an overflowing result leaving the adder sets it, and a
  // set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && bus.ovf) begin
      ovf_sticky_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_sticky_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit with WIDTH=8: directed
// vectors, an arithmetic reference model and a per-cycle scoreboard.
module tb_pipelined_adder_nbit;
  import adder_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t         m_q[$];
  logic         m_sticky = 1'b0;
  int           ns_cnt   = 0;
  int           run_len  = 0;
  int           max_run  = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;

  pipelined_adder_nbit_if #(.WIDTH(W)) bus ();

  pipelined_adder_nbit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow from operand signs.
  function automatic exp_t model_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                    input logic cin_v, input logic sub_v);
    exp_t         r;
    logic [W-1:0] bb;
    longint       tot;
    bb     = sub_v ? ~b_v : b_v;
    tot    = longint'(a_v) + longint'(bb) + (sub_v ? 64'd1 : longint'(cin_v));
    r.sum  = tot[W-1:0];
    r.cout = tot[W];
    r.ovf  = (a_v[W-1] == bb[W-1]) && (r.sum[W-1] != a_v[W-1]);
    r.acc  = 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pinModel(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic cin_v, input logic sub_v, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
    exp_t r;
    r = model_op(a_v, b_v, cin_v, sub_v);
    checkOutput({name, "_sum"},  64'(r.sum),  64'(e_sum));
    checkOutput({name, "_cout"}, 64'(r.cout), 64'(e_cout));
    checkOutput({name, "_ovf"},  64'(r.ovf),  64'(e_ovf));
  endtask

  // Holds in_valid with the operands until the adder takes them; leaves
  // in_valid high so consecutive calls issue back-to-back.
  task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic cin_v, input logic sub_v);
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a_v;
    bus.b        = b_v;
    bus.cin      = cin_v;
    bus.sub      = sub_v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic waitDrain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      @(posedge clk);
      #2;
      empty = (m_q.size() == 0);
    end
    if (!empty) checkOutput("drain_timeout", 64'(empty), 64'd1);
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
  endtask

  // Scoreboard: predicts out_valid, in_ready and sticky every cycle and
  // compares each transferred result, in issue order, with its latency.
  always @(negedge clk) begin
    logic exp_valid;
    logic stall_e;
    exp_t e;
    exp_t n;
    if (rst) begin
      m_q.delete();
      m_sticky = 1'b0;
      run_len  = 0;
    end else begin
      exp_valid = (m_q.size() > 0) && ((ns_cnt - m_q[0].acc) >= W);
      stall_e   = exp_valid && !bus.out_ready;
      checkOutput("out_valid",  64'(bus.out_valid),  64'(exp_valid));
      checkOutput("in_ready",   64'(bus.in_ready),   64'(!stall_e));
      checkOutput("ovf_sticky", 64'(bus.ovf_sticky), 64'(m_sticky));
      if (exp_valid && bus.out_ready) begin
        e = m_q.pop_front();
        checkOutput("sum",  64'(bus.sum),  64'(e.sum));
        checkOutput("cout", 64'(bus.cout), 64'(e.cout));
        checkOutput("ovf",  64'(bus.ovf),  64'(e.ovf));
        last_sum  = bus.sum;
        last_cout = bus.cout;
        last_ovf  = bus.ovf;
        if (e.ovf) m_sticky = 1'b1;
        else if (bus.ovf_clr) m_sticky = 1'b0;
      end else if (bus.ovf_clr) begin
        m_sticky = 1'b0;
      end
      if (!stall_e) begin
        if (bus.in_valid) begin
          n     = model_op(bus.a, bus.b, bus.cin, bus.sub);
          n.acc = ns_cnt;
          m_q.push_back(n);
        end
        ns_cnt++;
      end
      if (bus.out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = ADD;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;

    pinModel("pin_ff_p1",  8'hFF, 8'h01, 1'b0, ADD, 8'h00, 1'b1, 1'b0);
    pinModel("pin_7f_p1",  8'h7F, 8'h01, 1'b0, ADD, 8'h80, 1'b0, 1'b1);
    pinModel("pin_05_m07", 8'h05, 8'h07, 1'b0, SUB, 8'hFE, 1'b0, 1'b0);
    pinModel("pin_80_m01", 8'h80, 8'h01, 1'b0, SUB, 8'h7F, 1'b1, 1'b1);
    pinModel("pin_10_p20", 8'h10, 8'h20, 1'b0, ADD, 8'h30, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("rst_sum",        64'(bus.sum),        64'h00);
    checkOutput("rst_ovf_sticky", 64'(bus.ovf_sticky), 64'd0);
    checkOutput("rst_in_ready",   64'(bus.in_ready),   64'd1);

    // All-ones plus one wraps.
    @(posedge clk);
    #1;
    applyStimulus(8'hFF, 8'h01, 1'b0, ADD);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("wrap_sum",  64'(last_sum),  64'h00);
    checkOutput("wrap_cout", 64'(last_cout), 64'd1);
    checkOutput("wrap_ovf",  64'(last_ovf),  64'd0);

    // Signed overflow on add, sticky picks it up.
    applyStimulus(8'h7F, 8'h01, 1'b0, ADD);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("ovf_add_sum",    64'(last_sum),       64'h80);
    checkOutput("ovf_add_cout",   64'(last_cout),      64'd0);
    checkOutput("ovf_add_ovf",    64'(last_ovf),       64'd1);
    checkOutput("ovf_add_sticky", 64'(bus.ovf_sticky), 64'd1);

    // Subtraction with borrow, then signed overflow on subtract.
    applyStimulus(8'h05, 8'h07, 1'b1, SUB);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("sub_borrow_sum",  64'(last_sum),  64'hFE);
    checkOutput("sub_borrow_cout", 64'(last_cout), 64'd0);
    checkOutput("sub_borrow_ovf",  64'(last_ovf),  64'd0);
    applyStimulus(8'h80, 8'h01, 1'b0, SUB);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("sub_ovf_sum",  64'(last_sum),  64'h7F);
    checkOutput("sub_ovf_cout", 64'(last_cout), 64'd1);
    checkOutput("sub_ovf_ovf",  64'(last_ovf),  64'd1);

    pulseClear();
    #1;
    checkOutput("clr_sticky", 64'(bus.ovf_sticky), 64'd0);

    // Back-to-back random operations at full throughput.
    max_run = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("b2b_run_length", 64'(max_run), 64'd20);

    // Back-pressure with a full pipe.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h3C;
    bus.b         = 8'h0F;
    bus.cin       = 1'b1;
    bus.sub       = ADD;
    held          = bus.sum;
    checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("stall_sum_held", 64'(bus.sum),      64'(held));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(8'h3C, 8'h0F, 1'b1, ADD);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("stall_last_sum", 64'(last_sum), 64'h4C);

    // Clear and set in the same cycle: set wins.
    pulseClear();
    #1;
    checkOutput("pre_setclr_sticky", 64'(bus.ovf_sticky), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'h7F, 8'h01, 1'b0, ADD);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("setclr_out_valid", 64'(bus.out_valid),  64'd1);
    checkOutput("setclr_ovf",       64'(bus.ovf),        64'd1);
    checkOutput("setclr_before",    64'(bus.ovf_sticky), 64'd0);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    checkOutput("setclr_sticky", 64'(bus.ovf_sticky), 64'd1);

    // Reset with operations in flight discards them.
    applyStimulus(8'h01, 8'h02, 1'b0, ADD);
    applyStimulus(8'h7F, 8'h7F, 1'b0, ADD);
    applyStimulus(8'h33, 8'h11, 1'b0, SUB);
    applyStimulus(8'hF0, 8'h0F, 1'b1, ADD);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("midrst_sum",        64'(bus.sum),        64'h00);
    checkOutput("midrst_cout",       64'(bus.cout),       64'd0);
    checkOutput("midrst_ovf",        64'(bus.ovf),        64'd0);
    checkOutput("midrst_ovf_sticky", 64'(bus.ovf_sticky), 64'd0);
    checkOutput("midrst_in_ready",   64'(bus.in_ready),   64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    applyStimulus(8'h10, 8'h20, 1'b0, ADD);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("post_rst_sum", 64'(last_sum), 64'h30);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
- Parametrised successor to the single-bit clocked full adder.
- WIDTH-bit ripple-carry adder/subtractor, bit-level pipelined: one full-adder stage per bit, one register per stage.
- Accepts one operation per cycle. Adds a valid/ready handshake, global stall, subtract mode, signed overflow and a sticky overflow flag.
- Sits between operand splitters and accumulator logic in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands and mode valid this cycle.
- in_ready  output  1  adder accepts a new operation this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  signed overflow of this result.
- ovf_sticky  output  1  OR of ovf over all accepted results since the last clear.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids, sum, cout, ovf and ovf_sticky go to 0. in_ready=1 while rst is low.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stalled, every stage register holds its value.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Effective operands at entry: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage s (s = 0..WIDTH-1), on each non-stalled edge:
  - Computes sum bit s and carry c(s+1) from a[s], b_eff[s] and c(s).
  - Registers the accumulated sum bits 0..s, carry c(s+1), the not-yet-used operand bits s+1..WIDTH-1, and its valid bit.
  - Bubbles (valid=0) propagate; data in a bubble is don't-care, but the bench must not check it.
- Latency: a result accepted at non-stalled edge t appears with out_valid=1 after edge t+WIDTH-1, i.e. exactly WIDTH non-stalled edges later.
- Throughput: 1 result/cycle with out_ready held high.
- Output fields:
  - cout = c(WIDTH).
  - ovf = c(WIDTH) xor c(WIDTH-1), computed on b_eff; so it is correct for subtraction.
- ovf_sticky:
  - Set on an output transfer with ovf=1.
  - ovf_clr=1 clears it. If set and clear occur in the same cycle, set wins.
- Boundaries:
  - All-ones + 1 wraps sum to 0 with cout=1.
  - in_valid while in_ready=0: the operands are not captured; the source holds them.
  - rst mid-operation discards all in-flight results; no out_valid for them after release.
  - out_ready low with out_valid=0 does not stall; bubbles collapse behind the output stage.

Decomposition:
- Package adder_pkg:
  - ADD=1'b0 and SUB=1'b1 mode constants.
  - MAX_WIDTH=32.
  - Stage record typedef (valid, partial sum, carry, remaining a/b bits), sized by MAX_WIDTH and masked by WIDTH.
- Sub-module adder_stage:
  - One clocked full-adder bit plus pass-through registers.
  - Parameters STAGE_IDX and WIDTH; shared enable ~stall.
  - Instantiated WIDTH times in a generate loop.

Test Plan (WIDTH=8):
- Reset then idle, out_ready=1 -> out_valid=0, sum=0x00, ovf_sticky=0, in_ready=1.
- Add a=0xFF, b=0x01, cin=0 -> after 8 cycles sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1, ovf_sticky=1.
- Sub a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0. Sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- 20 back-to-back random ops with out_ready=1 -> 20 consecutive out_valid cycles, each matching the reference model, in issue order.
- Drop out_ready for 5 cycles with the pipe full -> in_ready=0, sum held stable, no result lost or duplicated after release. ovf_clr asserted in the same cycle as an ovf=1 transfer -> ovf_sticky stays 1.
- Assert rst with 4 ops in flight -> all outputs 0 immediately; after release no stale out_valid; next op a=0x10, b=0x20 -> sum=0x30.
